// File: rtl/plic_lite_if.sv
// Wishbone slave bundle for the interrupt controller register window.
interface plic_lite_if;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_ack_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/plic_lite.sv
// Platform-level interrupt controller: per-source gateways, priority arbiter,
// claim/complete register and machine external interrupt generation.
module plic_lite #(
  parameter int unsigned NSRC   = 8,
  parameter int unsigned PRIO_W = 3,
  parameter logic [31:0] BASE   = 32'h0C00_0000
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  plic_lite_if.slave          wb,
  input  logic [NSRC-1:0]     irq_src_i,
  input  logic [31:0]         csr_mie,
  input  logic [31:0]         csr_mstatus,
  output logic                Interrupt,
  output logic [30:0]         Exception_code
);

  localparam int unsigned IDW         = $clog2(NSRC);
  localparam logic [31:0] OFF_PENDING = 32'h0000_1000;
  localparam logic [31:0] OFF_ENABLE  = 32'h0000_2000;
  localparam logic [31:0] OFF_THRESH  = 32'h0020_0000;
  localparam logic [31:0] OFF_CLAIM   = 32'h0020_0004;
  localparam logic [30:0] CAUSE_MEI   = 31'd11;

  typedef enum logic [1:0] {
    GW_IDLE   = 2'd0,
    GW_PEND   = 2'd1,
    GW_FLIGHT = 2'd2
  } gw_state_e;

  // Bus-side registers
  logic              ack_q, ack_d;
  logic [31:0]       rdata_q, rdata_d;

  // Configuration registers
  logic [PRIO_W-1:0] prio_q [NSRC];
  logic [PRIO_W-1:0] prio_d [NSRC];
  logic [NSRC-1:0]   enable_q, enable_d;
  logic [PRIO_W-1:0] thr_q, thr_d;

  // Gateway state per source
  gw_state_e         gw_q [NSRC];
  gw_state_e         gw_d [NSRC];

  // Arbiter and interrupt output registers
  logic [IDW-1:0]    best_q, best_d;
  logic [PRIO_W-1:0] best_prio_c;
  logic              intr_q, intr_d;
  logic [30:0]       code_q, code_d;

  // Decode signals
  logic              access_c;
  logic              rd_c;
  logic              wr_c;
  logic [31:0]       off_c;
  logic              prio_hit_c;
  logic              pend_hit_c;
  logic              en_hit_c;
  logic              thr_hit_c;
  logic              claim_hit_c;
  logic [IDW-1:0]    prio_idx_c;
  logic              claim_c;
  logic              complete_c;
  logic [IDW-1:0]    comp_id_c;
  logic [NSRC-1:0]   pending_c;
  logic              unused_c;

  assign wb.wb_ack_o    = ack_q;
  assign wb.wb_dat_o    = rdata_q;
  assign Interrupt      = intr_q;
  assign Exception_code = code_q;

  // Bits of the CSRs, write data and address offset that the decode does not consume
  assign unused_c = ^{csr_mie, csr_mstatus, wb.wb_dat_i, irq_src_i[0], off_c};

  // Access qualification and register window decode; an access is only taken while ack is low
  always_comb begin
    access_c    = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q;
    rd_c        = access_c & ~wb.wb_we_i;
    wr_c        = access_c & wb.wb_we_i & (wb.wb_sel_i == 4'hF);
    off_c       = wb.wb_adr_i - BASE;
    prio_hit_c  = (off_c[1:0] == 2'b00) && (off_c[31:2] != 30'd0) && (off_c[31:2] < 30'(NSRC));
    prio_idx_c  = off_c[IDW+1:2];
    pend_hit_c  = (off_c == OFF_PENDING);
    en_hit_c    = (off_c == OFF_ENABLE);
    thr_hit_c   = (off_c == OFF_THRESH);
    claim_hit_c = (off_c == OFF_CLAIM);
    claim_c     = rd_c & claim_hit_c & (best_q != '0);
    complete_c  = wr_c & claim_hit_c & (wb.wb_dat_i != 32'd0) & (wb.wb_dat_i < 32'(NSRC));
    comp_id_c   = wb.wb_dat_i[IDW-1:0];
  end

  // Read data mux and single-cycle acknowledge
  always_comb begin
    ack_d   = access_c;
    rdata_d = rdata_q;
    if (rd_c) begin
      rdata_d = 32'd0;
      if (prio_hit_c) begin
        rdata_d = 32'(prio_q[prio_idx_c]);
      end else if (pend_hit_c) begin
        rdata_d = 32'(pending_c);
      end else if (en_hit_c) begin
        rdata_d = 32'(enable_q);
      end else if (thr_hit_c) begin
        rdata_d = 32'(thr_q);
      end else if (claim_hit_c) begin
        rdata_d = 32'(best_q);
      end
    end
  end

  // Bus registers
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
    end
  end

  // Configuration write decode; id 0 has no priority and can never be enabled
  always_comb begin
    prio_d   = prio_q;
    enable_d = enable_q;
    thr_d    = thr_q;
    if (wr_c) begin
      if (prio_hit_c) begin
        prio_d[prio_idx_c] = wb.wb_dat_i[PRIO_W-1:0];
      end
      if (en_hit_c) begin
        enable_d = wb.wb_dat_i[NSRC-1:0] & ~NSRC'(1);
      end
      if (thr_hit_c) begin
        thr_d = wb.wb_dat_i[PRIO_W-1:0];
      end
    end
    prio_d[0] = '0;
  end

  // Configuration registers
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < NSRC; i++) begin
        prio_q[i] <= '0;
      end
      enable_q <= '0;
      thr_q    <= '0;
    end else begin
      prio_q   <= prio_d;
      enable_q <= enable_d;
      thr_q    <= thr_d;
    end
  end

  // Gateway state register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < NSRC; i++) begin
        gw_q[i] <= GW_IDLE;
      end
    end else begin
      gw_q <= gw_d;
    end
  end

  // Gateway next state: latch a rising level, hand off on claim, re-arm on complete
  always_comb begin
    gw_d = gw_q;
    gw_d[0] = GW_IDLE;
    for (int i = 1; i < NSRC; i++) begin
      case (gw_q[i])
        GW_IDLE: begin
          if (irq_src_i[i]) begin
            gw_d[i] = GW_PEND;
          end
        end
        GW_PEND: begin
          if (claim_c && (best_q == IDW'(i))) begin
            gw_d[i] = GW_FLIGHT;
          end
        end
        GW_FLIGHT: begin
          if (complete_c && (comp_id_c == IDW'(i))) begin
            gw_d[i] = GW_IDLE;
          end
        end
        default: gw_d[i] = GW_IDLE;
      endcase
    end
  end

  // Gateway outputs: pending bit per source
  always_comb begin
    pending_c = '0;
    for (int i = 1; i < NSRC; i++) begin
      pending_c[i] = (gw_q[i] == GW_PEND);
    end
  end

  // Priority arbiter: strictly-greater compare in ascending id order gives lowest id on ties
  always_comb begin
    best_d      = '0;
    best_prio_c = '0;
    for (int i = 1; i < NSRC; i++) begin
      if (pending_c[i] && enable_q[i] && (prio_q[i] > thr_q) && (prio_q[i] > best_prio_c)) begin
        best_d      = IDW'(i);
        best_prio_c = prio_q[i];
      end
    end
  end

  // Machine external interrupt request, masked by MEIE and global MIE
  always_comb begin
    intr_d = (best_q != '0) & csr_mstatus[3] & csr_mie[11];
    code_d = intr_d ? CAUSE_MEI : 31'd0;
  end

  // Arbiter result and interrupt output registers
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      best_q <= '0;
      intr_q <= 1'b0;
      code_q <= 31'd0;
    end else begin
      best_q <= best_d;
      intr_q <= intr_d;
      code_q <= code_d;
    end
  end

endmodule

// File: tb/tb_plic_lite.sv
// Self-checking bench for plic_lite: bus reads scored through an expected-value queue.
module tb_plic_lite;
  localparam logic [31:0] BASE    = 32'h0C00_0000;
  localparam logic [31:0] A_PEND  = BASE + 32'h0000_1000;
  localparam logic [31:0] A_EN    = BASE + 32'h0000_2000;
  localparam logic [31:0] A_THR   = BASE + 32'h0020_0000;
  localparam logic [31:0] A_CLAIM = BASE + 32'h0020_0004;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  irq;
  logic [31:0] mie;
  logic [31:0] mstatus;
  logic        intr;
  logic [30:0] code;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  plic_lite_if bus();

  plic_lite #(.NSRC(8), .PRIO_W(3), .BASE(BASE)) dut (
    .wb_clk_i       (clk),
    .wb_rst_i       (rst),
    .wb             (bus),
    .irq_src_i      (irq),
    .csr_mie        (mie),
    .csr_mstatus    (mstatus),
    .Interrupt      (intr),
    .Exception_code (code)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One bus access; a read pushes its expectation and pops it when ack arrives
  task automatic bus_xfer(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                          input logic [3:0] sel, input logic [31:0] exp, input string tag);
    int          n;
    logic [31:0] e;
    string       t;
    @(negedge clk);
    if (!we) begin
      exp_q.push_back(exp);
      tag_q.push_back(tag);
    end
    bus.wb_adr_i = adr;
    bus.wb_we_i  = we;
    bus.wb_dat_i = wdat;
    bus.wb_sel_i = sel;
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.wb_ack_o && n < 16);
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
    check({tag, "_ack"}, 32'(bus.wb_ack_o), 32'd1);
    if (!we && bus.wb_ack_o) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check(t, bus.wb_dat_o, e);
    end
  endtask

  task automatic rd(input logic [31:0] adr, input logic [31:0] exp, input string tag);
    bus_xfer(1'b0, adr, 32'd0, 4'hF, exp, tag);
  endtask

  task automatic wr(input logic [31:0] adr, input logic [31:0] dat, input string tag);
    bus_xfer(1'b1, adr, dat, 4'hF, 32'd0, tag);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    logic [31:0] e;
    string       t;
    rst          = 1'b1;
    irq          = 8'h00;
    mie          = 32'd0;
    mstatus      = 32'd0;
    bus.wb_adr_i = 32'd0;
    bus.wb_dat_i = 32'd0;
    bus.wb_sel_i = 4'h0;
    bus.wb_we_i  = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_cyc_i = 1'b0;
    tick(3);
    check("rst_intr", 32'(intr), 32'd0);
    check("rst_code", 32'(code), 32'd0);
    check("rst_ack", 32'(bus.wb_ack_o), 32'd0);
    check("rst_dat", bus.wb_dat_o, 32'd0);
    rst = 1'b0;
    rd(A_PEND, 32'd0, "rst_pend");
    rd(A_EN, 32'd0, "rst_en");
    rd(A_THR, 32'd0, "rst_thr");
    rd(A_CLAIM, 32'd0, "rst_claim");

    // Basic path: src3 rise to interrupt latency, claim, complete
    mie     = 32'h0000_0800;
    mstatus = 32'h0000_0008;
    wr(BASE + 32'd12, 32'd2, "t1_prio3");
    wr(A_EN, 32'h08, "t1_en");
    wr(A_THR, 32'd0, "t1_thr");
    irq[3] = 1'b1;
    tick(2);
    check("t1_intr_t2", 32'(intr), 32'd0);
    tick(1);
    check("t1_intr_t3", 32'(intr), 32'd1);
    check("t1_code", 32'(code), 32'd11);
    rd(A_CLAIM, 32'd3, "t1_claim");
    tick(2);
    check("t1_intr_drop", 32'(intr), 32'd0);
    check("t1_code_drop", 32'(code), 32'd0);
    irq[3] = 1'b0;
    wr(A_CLAIM, 32'd3, "t1_complete");
    rd(A_PEND, 32'd0, "t1_pend_clear");

    // Priority order with tie broken by lowest id
    wr(BASE + 32'd8,  32'd5, "t2_prio2");
    wr(BASE + 32'd20, 32'd5, "t2_prio5");
    wr(BASE + 32'd24, 32'd4, "t2_prio6");
    wr(A_EN, 32'h64, "t2_en");
    irq = 8'h64;
    tick(1);
    irq = 8'h00;
    tick(3);
    rd(A_PEND, 32'h64, "t2_pend");
    rd(A_CLAIM, 32'd2, "t2_claim2");
    wr(A_CLAIM, 32'd2, "t2_cpl2");
    rd(A_CLAIM, 32'd5, "t2_claim5");
    wr(A_CLAIM, 32'd5, "t2_cpl5");
    rd(A_CLAIM, 32'd6, "t2_claim6");
    wr(A_CLAIM, 32'd6, "t2_cpl6");
    rd(A_CLAIM, 32'd0, "t2_claim_none");

    // Threshold equal to priority masks; lowering it unmasks
    wr(A_EN, 32'h10, "t3_en");
    wr(BASE + 32'd16, 32'd5, "t3_prio4");
    wr(A_THR, 32'd5, "t3_thr5");
    irq[4] = 1'b1;
    tick(1);
    irq[4] = 1'b0;
    tick(4);
    check("t3_intr_masked", 32'(intr), 32'd0);
    rd(A_CLAIM, 32'd0, "t3_claim_masked");
    rd(A_PEND, 32'h10, "t3_pend");
    wr(A_THR, 32'd4, "t3_thr4");
    tick(3);
    check("t3_intr_unmasked", 32'(intr), 32'd1);
    rd(A_CLAIM, 32'd4, "t3_claim4");
    wr(A_CLAIM, 32'd4, "t3_cpl4");
    wr(A_THR, 32'd0, "t3_thr0");

    // Level held through complete re-pends
    wr(BASE + 32'd4, 32'd1, "t4_prio1");
    wr(A_EN, 32'h02, "t4_en");
    irq[1] = 1'b1;
    tick(4);
    check("t4_intr", 32'(intr), 32'd1);
    rd(A_CLAIM, 32'd1, "t4_claim1");
    wr(A_CLAIM, 32'd1, "t4_cpl1");
    rd(A_PEND, 32'h02, "t4_repend");
    n = 0;
    while (!intr && n < 8) begin
      tick(1);
      n++;
    end
    check("t4_intr_reassert", 32'(intr), 32'd1);
    irq[1] = 1'b0;
    rd(A_CLAIM, 32'd1, "t4_claim1b");
    wr(A_CLAIM, 32'd1, "t4_cpl1b");
    tick(3);
    check("t4_intr_idle", 32'(intr), 32'd0);

    // Ignored complete, partial byte-select write, unmapped and reserved reads
    wr(A_EN, 32'h80, "t5_en");
    wr(BASE + 32'd28, 32'd3, "t5_prio7");
    wr(A_CLAIM, 32'd7, "t5_cpl_idle");
    wr(A_CLAIM, 32'd9, "t5_cpl_range");
    rd(A_PEND, 32'd0, "t5_pend_none");
    irq[7] = 1'b1;
    tick(1);
    irq[7] = 1'b0;
    tick(3);
    rd(A_CLAIM, 32'd7, "t5_claim7");
    wr(A_CLAIM, 32'd7, "t5_cpl7");
    bus_xfer(1'b1, BASE + 32'd28, 32'd5, 4'h3, 32'd0, "t5_sel3");
    rd(BASE + 32'd28, 32'd3, "t5_prio7_kept");
    bus_xfer(1'b1, A_THR, 32'd7, 4'h1, 32'd0, "t5_sel1");
    rd(A_THR, 32'd0, "t5_thr_kept");
    rd(BASE + 32'h1004, 32'd0, "t5_unmapped");
    rd(BASE, 32'd0, "t5_prio0");
    wr(A_EN, 32'hFF, "t5_en_all");
    rd(A_EN, 32'hFE, "t5_en_bit0");
    wr(A_EN, 32'h24, "t6_en");

    // Reset during ack with a source in flight
    wr(BASE + 32'd8, 32'd5, "t6_prio2");
    irq[2] = 1'b1;
    tick(4);
    rd(A_CLAIM, 32'd2, "t6_claim2");
    irq[5] = 1'b1;
    tick(1);
    irq[5] = 1'b0;
    tick(3);
    check("t6_intr_pre", 32'(intr), 32'd1);
    @(negedge clk);
    exp_q.push_back(32'd5);
    tag_q.push_back("t6_rd_prio2");
    bus.wb_adr_i = BASE + 32'd8;
    bus.wb_we_i  = 1'b0;
    bus.wb_sel_i = 4'hF;
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.wb_ack_o && n < 16);
    check("t6_ack", 32'(bus.wb_ack_o), 32'd1);
    if (bus.wb_ack_o) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check(t, bus.wb_dat_o, e);
    end
    rst          = 1'b1;
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    @(negedge clk);
    check("t6_rst_ack", 32'(bus.wb_ack_o), 32'd0);
    check("t6_rst_dat", bus.wb_dat_o, 32'd0);
    check("t6_rst_intr", 32'(intr), 32'd0);
    check("t6_rst_code", 32'(code), 32'd0);
    rst = 1'b0;
    tick(2);
    rd(A_PEND, 32'h04, "t6_pend_src2_only");
    rd(BASE + 32'd8, 32'd0, "t6_prio2_rst");
    rd(A_EN, 32'd0, "t6_en_rst");
    check("t6_intr_post", 32'(intr), 32'd0);
    irq = 8'h00;
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
